inst_fetch: RTL and testbench
=============================

# inst_fetch

Fetch stage of the out-of-order core: owns the architectural fetch PC, issues one-word requests to the instruction cache, and queries the branch predictor with the current PC. It computes the predicted next PC for conditional branches and JAL, pushes {instruction, PC, prediction} into the instruction queue, and redirects on back-end flush. It also registers resolved-branch outcomes from the back end and forwards them to the predictor as training feedback.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC after reset
- DAT_W, 32, data/address width (`DAT_W)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- en  in  1  global ready; when low all state freezes
- ic_req_o  out  1  one-cycle request strobe to icache
- ic_addr_o  out  32  request address
- ic_valid_i  in  1  response valid, one cycle
- ic_inst_i  in  32  response instruction
- bp_pc_o  out  32  PC presented to predictor
- bp_br_i  in  1  predictor says taken (combinational from bp_pc_o)
- bp_fb_en_o  out  1  training strobe to predictor
- bp_fb_abr_o  out  1  actually taken
- bp_fb_tpc_o  out  32  PC of the resolved branch
- iq_full_i  in  1  instruction queue cannot accept
- iq_push_o  out  1  push strobe
- iq_inst_o  out  32  instruction
- iq_pc_o  out  32  its PC
- iq_pred_o  out  1  predicted taken
- iq_npc_o  out  32  predicted next PC
- br_en_i  in  1  back end resolved a conditional branch
- br_taken_i  in  1  resolved direction
- br_pc_i  in  32  resolved branch PC
- flush_i  in  1  redirect (mispredict / JALR)
- flush_pc_i  in  32  redirect target

## Operation
- States: IDLE, WAIT, HOLD, DROP. Reset: state=IDLE, pc=RESET_PC, held inst cleared; all outputs 0 except ic_addr_o=bp_pc_o=RESET_PC.
- IDLE: ic_req_o=1, ic_addr_o=pc; next WAIT.
- WAIT: on ic_valid_i: if !iq_full_i push same cycle, pc<=npc, next IDLE; else latch inst into HOLD register, next HOLD.
- HOLD: push held inst when !iq_full_i, pc<=npc, next IDLE.
- DROP: entered on flush while WAIT; waits for ic_valid_i, discards it, next IDLE. No request issued in DROP.
- Next-PC: opcode 1101111 (JAL): pred=1, npc=pc+immJ. Opcode 1100011 (branch): pred=bp_br_i, npc=pred?pc+immB:pc+4. All else (incl. JALR): pred=0, npc=pc+4. Immediates sign-extended, sums mod 2^32.
- bp_pc_o always equals pc.
- Flush (en high): pc<=flush_pc_i, no push that cycle. From IDLE/HOLD -> IDLE; from WAIT -> DROP unless ic_valid_i same cycle (response discarded, -> IDLE); in DROP stays DROP until response, then IDLE. Flush has priority over push and over request: in IDLE the flush cycle issues no request.
- Feedback: bp_fb_en_o/abr/tpc <= br_en_i/br_taken_i/br_pc_i registered, one cycle later; en low forces bp_fb_en_o=0 next edge.
- en low: no state or pc change; iq_push_o=0, ic_req_o=0; pending icache response arriving while en low is captured into HOLD (state WAIT->HOLD) so it is never lost.

## Timing
- Request to push: request in cycle t (IDLE), response earliest t+1, push combinational in response cycle; peak throughput 1 instruction per 2 cycles.
- Push outputs valid only while iq_push_o=1; prediction uses bp_br_i in the push cycle (HOLD: re-sampled when pushing).
- Flush-to-request: flush at t, request at new PC at t+1 (from IDLE/HOLD), or cycle after discarded response (from WAIT).
- Reset asynchronous, deasserts synchronously to clk; mid-WAIT reset abandons transaction, any later stray response ignored in IDLE.

## Test plan
- Reset, sequential ALU words, icache latency 1 -> pushes at PC 0,4,8 every 2 cycles, iq_npc_o=pc+4, iq_pred_o=0.
- Branch at 0x10 with immB=+0x20, bp_br_i=1 -> iq_npc_o=0x30, next ic_addr_o=0x30; with bp_br_i=0 -> 0x14.
- JAL at 0x40 immJ=-0x40 -> iq_pred_o=1, iq_npc_o=0x0.
- iq_full_i high 3 cycles on response -> HOLD, push exactly once when it drops, no duplicate request.
- flush_i (flush_pc_i=0x100) in WAIT, response 2 cycles later -> response dropped, no push, next request addr 0x100.
- br_en_i=1, br_taken_i=0, br_pc_i=0x24 -> next cycle bp_fb_en_o=1, abr=0, tpc=0x24, single cycle.

Source files
------------

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: icache, predictor, instruction-queue and back-end signals of the fetch stage.
interface inst_fetch_if #(parameter int DAT_W = 32);
  logic             ic_req_o;
  logic [DAT_W-1:0] ic_addr_o;
  logic             ic_valid_i;
  logic [DAT_W-1:0] ic_inst_i;
  logic [DAT_W-1:0] bp_pc_o;
  logic             bp_br_i;
  logic             bp_fb_en_o;
  logic             bp_fb_abr_o;
  logic [DAT_W-1:0] bp_fb_tpc_o;
  logic             iq_full_i;
  logic             iq_push_o;
  logic [DAT_W-1:0] iq_inst_o;
  logic [DAT_W-1:0] iq_pc_o;
  logic             iq_pred_o;
  logic [DAT_W-1:0] iq_npc_o;
  logic             br_en_i;
  logic             br_taken_i;
  logic [DAT_W-1:0] br_pc_i;
  logic             flush_i;
  logic [DAT_W-1:0] flush_pc_i;
  modport master (
    output ic_req_o, ic_addr_o, bp_pc_o, bp_fb_en_o, bp_fb_abr_o, bp_fb_tpc_o,
           iq_push_o, iq_inst_o, iq_pc_o, iq_pred_o, iq_npc_o,
    input  ic_valid_i, ic_inst_i, bp_br_i, iq_full_i, br_en_i, br_taken_i, br_pc_i,
           flush_i, flush_pc_i
  );
  modport slave (
    input  ic_req_o, ic_addr_o, bp_pc_o, bp_fb_en_o, bp_fb_abr_o, bp_fb_tpc_o,
           iq_push_o, iq_inst_o, iq_pc_o, iq_pred_o, iq_npc_o,
    output ic_valid_i, ic_inst_i, bp_br_i, iq_full_i, br_en_i, br_taken_i, br_pc_i,
           flush_i, flush_pc_i
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: fetch PC owner; one-word icache requests, next-PC prediction, IQ push, flush redirect.
module inst_fetch #(
  parameter int               DAT_W    = 32,
  parameter logic [DAT_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  inst_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_e;
  state_e           state_q, state_d;
  logic [DAT_W-1:0] pc_q, pc_d, hold_q, hold_d, inst, imm_j, imm_b, npc, fb_tpc_q;
  logic             pred, resp, push, fb_en_q, fb_abr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      hold_q   <= '0;
      fb_en_q  <= 1'b0;
      fb_abr_q <= 1'b0;
      fb_tpc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      fb_en_q <= en && bus.br_en_i;
      if (en) begin
        fb_abr_q <= bus.br_taken_i;
        fb_tpc_q <= bus.br_pc_i;
      end
    end
  end
  assign inst  = state_q == HOLD ? hold_q : bus.ic_inst_i;
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign pred  = inst[6:0] == 7'b1101111 || (inst[6:0] == 7'b1100011 && bus.bp_br_i);
  assign npc   = pc_q + (!pred ? DAT_W'(4) : inst[6:0] == 7'b1101111 ? imm_j : imm_b);
  assign resp  = state_q == WAIT && bus.ic_valid_i;
  assign push  = en && !bus.flush_i && !bus.iq_full_i && (resp || state_q == HOLD);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    if (!en) begin
      // a response arriving while stalled is parked in HOLD; a dropped one still retires DROP
      state_d = resp ? HOLD : (state_q == DROP && bus.ic_valid_i) ? IDLE : state_q;
      hold_d  = resp ? bus.ic_inst_i : hold_q;
    end else if (bus.flush_i) begin
      pc_d    = bus.flush_pc_i;
      state_d = (state_q == WAIT || state_q == DROP) && !bus.ic_valid_i ? DROP : IDLE;
    end else begin
      pc_d    = push ? npc : pc_q;
      state_d = state_q == IDLE ? WAIT : push ? IDLE : resp ? HOLD :
                (state_q == DROP && bus.ic_valid_i) ? IDLE : state_q;
      hold_d  = resp && bus.iq_full_i ? bus.ic_inst_i : hold_q;
    end
  end
  always_comb begin
    bus.ic_req_o    = rst && en && !bus.flush_i && state_q == IDLE;
    bus.ic_addr_o   = pc_q;
    bus.bp_pc_o     = pc_q;
    bus.iq_push_o   = rst && push;
    bus.iq_inst_o   = bus.iq_push_o ? inst : '0;
    bus.iq_pc_o     = bus.iq_push_o ? pc_q : '0;
    bus.iq_pred_o   = bus.iq_push_o && pred;
    bus.iq_npc_o    = bus.iq_push_o ? npc : '0;
    bus.bp_fb_en_o  = fb_en_q;
    bus.bp_fb_abr_o = fb_abr_q;
    bus.bp_fb_tpc_o = fb_tpc_q;
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed fetch sequences; expected requests and pushes queued, checked by a monitor.
module tb_inst_fetch;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BR32 = 32'h0200_0063;
  localparam logic [31:0] BR12 = 32'h0000_0663;
  localparam logic [31:0] JALM = 32'hFC1F_F06F;
  typedef struct packed {logic [31:0] inst, pc; logic pred; logic [31:0] npc;} push_t;
  logic clk = 0, rst = 0, en = 1;
  int checks = 0, passed = 0;
  logic [31:0] exp_req[$];
  push_t exp_push[$];
  inst_fetch_if #(.DAT_W(32)) bus();
  inst_fetch #(.DAT_W(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .en(en), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] inst, input logic br, input logic [31:0] pc,
                       input logic pred, input logic [31:0] npc);
    exp_req.push_back(pc);
    exp_push.push_back('{inst, pc, pred, npc});
    cyc;
    bus.ic_valid_i = 1; bus.ic_inst_i = inst; bus.bp_br_i = br;
    cyc;
    bus.ic_valid_i = 0; bus.bp_br_i = 0;
  endtask
  always @(negedge clk) begin
    if (bus.ic_req_o) begin
      if (exp_req.size() == 0) begin
        checks++;
        $display("FAIL req_unexpected: got addr %h expected no request", bus.ic_addr_o);
      end else chk("req_addr", bus.ic_addr_o, exp_req.pop_front());
    end
    if (bus.iq_push_o) begin
      if (exp_push.size() == 0) begin
        checks++;
        $display("FAIL push_unexpected: got pc %h expected no push", bus.iq_pc_o);
      end else begin
        push_t e;
        e = exp_push.pop_front();
        chk("push_inst", bus.iq_inst_o, e.inst);
        chk("push_pc", bus.iq_pc_o, e.pc);
        chk("push_pred", 32'(bus.iq_pred_o), 32'(e.pred));
        chk("push_npc", bus.iq_npc_o, e.npc);
      end
    end
  end
  initial begin
    bus.ic_valid_i = 0; bus.ic_inst_i = 0; bus.bp_br_i = 0; bus.iq_full_i = 0;
    bus.br_en_i = 0; bus.br_taken_i = 0; bus.br_pc_i = 0; bus.flush_i = 0; bus.flush_pc_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.ic_req_o), 0);
    chk("rst_addr", bus.ic_addr_o, 32'h0);
    chk("rst_bp_pc", bus.bp_pc_o, 32'h0);
    chk("rst_push", 32'(bus.iq_push_o), 0);
    chk("rst_fb_en", 32'(bus.bp_fb_en_o), 0);
    cyc;
    rst = 1;
    fetch(NOP, 0, 32'h00, 0, 32'h04);
    fetch(NOP, 0, 32'h04, 0, 32'h08);
    fetch(NOP, 0, 32'h08, 0, 32'h0C);
    fetch(NOP, 0, 32'h0C, 0, 32'h10);
    fetch(BR32, 1, 32'h10, 1, 32'h30);
    fetch(BR32, 0, 32'h30, 0, 32'h34);
    fetch(BR12, 1, 32'h34, 1, 32'h40);
    fetch(JALM, 0, 32'h40, 1, 32'h00);
    // iq full for 3 cycles; prediction re-sampled at the HOLD push
    exp_req.push_back(32'h0);
    exp_push.push_back('{BR12, 32'h0, 1'b1, 32'h0C});
    cyc;
    bus.ic_valid_i = 1; bus.ic_inst_i = BR12; bus.iq_full_i = 1;
    cyc;
    bus.ic_valid_i = 0;
    cyc;
    cyc;
    bus.iq_full_i = 0; bus.bp_br_i = 1;
    cyc;
    bus.bp_br_i = 0;
    // flush in WAIT, response two cycles later is dropped
    exp_req.push_back(32'h0C);
    cyc;
    bus.flush_i = 1; bus.flush_pc_i = 32'h100;
    cyc;
    bus.flush_i = 0;
    cyc;
    bus.ic_valid_i = 1; bus.ic_inst_i = NOP;
    cyc;
    bus.ic_valid_i = 0;
    fetch(NOP, 0, 32'h100, 0, 32'h104);
    // flush in IDLE suppresses the request
    bus.flush_i = 1; bus.flush_pc_i = 32'h200;
    cyc;
    bus.flush_i = 0;
    fetch(NOP, 0, 32'h200, 0, 32'h204);
    // flush in WAIT with the response in the same cycle
    exp_req.push_back(32'h204);
    cyc;
    bus.flush_i = 1; bus.flush_pc_i = 32'h300; bus.ic_valid_i = 1; bus.ic_inst_i = NOP;
    cyc;
    bus.flush_i = 0; bus.ic_valid_i = 0;
    fetch(NOP, 0, 32'h300, 0, 32'h304);
    // response arriving while en low is held and pushed once en returns
    exp_req.push_back(32'h304);
    exp_push.push_back('{NOP, 32'h304, 1'b0, 32'h308});
    cyc;
    en = 0; bus.ic_valid_i = 1; bus.ic_inst_i = NOP;
    cyc;
    bus.ic_valid_i = 0;
    cyc;
    en = 1;
    cyc;
    fetch(NOP, 0, 32'h308, 0, 32'h30C);
    // feedback registered one cycle, single-cycle strobe; DUT sits in WAIT meanwhile
    exp_req.push_back(32'h30C);
    bus.br_en_i = 1; bus.br_taken_i = 0; bus.br_pc_i = 32'h24;
    cyc;
    bus.br_taken_i = 1; bus.br_pc_i = 32'h48;
    @(negedge clk);
    chk("fb_en_1", 32'(bus.bp_fb_en_o), 1);
    chk("fb_abr_1", 32'(bus.bp_fb_abr_o), 0);
    chk("fb_tpc_1", bus.bp_fb_tpc_o, 32'h24);
    cyc;
    bus.br_en_i = 0;
    @(negedge clk);
    chk("fb_en_2", 32'(bus.bp_fb_en_o), 1);
    chk("fb_abr_2", 32'(bus.bp_fb_abr_o), 1);
    chk("fb_tpc_2", bus.bp_fb_tpc_o, 32'h48);
    cyc;
    @(negedge clk);
    chk("fb_en_off", 32'(bus.bp_fb_en_o), 0);
    chk("bp_pc_wait", bus.bp_pc_o, 32'h30C);
    chk("req_left", 32'(exp_req.size()), 0);
    chk("push_left", 32'(exp_push.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
